// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Instruction-memory request/response bus between fetch and memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : PC owner, credit-limited fetch, instruction FIFO, flush drop.
//            Optional zero-latency bypass enabled by FETCH_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              hold_i,
  fetch_unit_if.master      mem,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_inst_o,
  output logic [ADDR_W-1:0] if_pc_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  wptr_q, wptr_d;
  logic [CNT_W-1:0]  rptr_q, rptr_d;
  logic              run_q;
  logic [DATA_W-1:0] inst_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];

  logic [CNT_W-1:0]  w_cnt;
  logic              w_empty, w_full, w_credit;
  logic              w_issue, w_keep, w_push, w_pop;
  logic [ADDR_W-1:0] w_flush_pc;
  logic [PTR_W-1:0]  w_widx, w_ridx;
  logic              w_unused;

  assign w_cnt      = wptr_q - rptr_q;
  assign w_empty    = (w_cnt == '0);
  assign w_full     = (w_cnt == CNT_W'(FIFO_DEPTH));
  // Credit covers both buffered entries and requests still in flight.
  assign w_credit   = ({1'b0, out_q} + {1'b0, w_cnt}) < (CNT_W+1)'(FIFO_DEPTH);
  assign w_flush_pc = {flush_pc_i[ADDR_W-1:2], 2'b00};
  assign w_unused   = ^flush_pc_i[1:0];
  assign w_widx     = wptr_q[PTR_W-1:0];
  assign w_ridx     = rptr_q[PTR_W-1:0];

  assign mem.req_valid = run_q & ~flush_i & w_credit;
  assign mem.req_addr  = pc_q;
  assign w_issue       = mem.req_valid & mem.req_ready;
  assign w_keep        = mem.rsp_valid & ~flush_i & (drop_q == '0);
  assign w_pop         = ~w_empty & ~hold_i & ~flush_i;

`ifdef FETCH_BYPASS_EN
  logic w_byp;
  assign w_byp      = w_keep & w_empty;
  assign w_push     = w_keep & ~(w_byp & ~hold_i);
  assign if_valid_o = ~w_empty | w_byp;
  assign if_inst_o  = w_byp ? mem.rsp_data : inst_mem_q[w_ridx];
  assign if_pc_o    = w_byp ? rsp_pc_q     : pc_mem_q[w_ridx];
`else
  assign w_push     = w_keep;
  assign if_valid_o = ~w_empty;
  assign if_inst_o  = inst_mem_q[w_ridx];
  assign if_pc_o    = pc_mem_q[w_ridx];
`endif

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q + CNT_W'(w_issue) - CNT_W'(mem.rsp_valid);
    drop_d   = drop_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    if (flush_i) begin
      // Everything still in flight after this cycle is stale.
      pc_d     = w_flush_pc;
      rsp_pc_d = w_flush_pc;
      drop_d   = out_q - CNT_W'(mem.rsp_valid);
      wptr_d   = '0;
      rptr_d   = '0;
    end else begin
      if (w_issue) pc_d = pc_q + ADDR_W'(4);
      if (mem.rsp_valid) begin
        if (drop_q != '0) drop_d = drop_q - CNT_W'(1);
        else              rsp_pc_d = rsp_pc_q + ADDR_W'(4);
      end
      if (w_push) wptr_d = wptr_q + CNT_W'(1);
      if (w_pop)  rptr_d = rptr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      run_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      run_q    <= 1'b1;
      if (w_push) begin
        inst_mem_q[w_widx] <= mem.rsp_data;
        pc_mem_q[w_widx]   <= rsp_pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(w_push && w_full && !w_pop));
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed bench for fetch_unit with an in-order latency memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        hold_i = 1'b0;
  logic        if_valid_o;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;

  fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .hold_i(hold_i), .mem(bus), .if_valid_o(if_valid_o),
    .if_inst_o(if_inst_o), .if_pc_o(if_pc_o)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat     = 1;
  int          cyc     = 0;
  logic [31:0] exp_req = '0;
  logic [31:0] exp_pc  = '0;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // In-order memory: request accepted in cycle c answers in cycle c+lat.
  initial begin
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.req_valid && bus.req_ready) begin
        q_addr.push_back(bus.req_addr);
        q_due.push_back(cyc + lat);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        q_addr.delete();
        q_due.delete();
        bus.rsp_valid = 1'b0;
      end else if (q_addr.size() > 0 && q_due[0] <= cyc) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = mem_word(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        bus.rsp_valid = 1'b0;
      end
    end
  end

  // One cycle: score accepted requests and pops, then advance to posedge+2.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (bus.req_valid && bus.req_ready) begin
        check("req_addr_seq", bus.req_addr, exp_req);
        exp_req += 32'd4;
      end
      if (if_valid_o && !hold_i && !flush_i) begin
        check("if_pc_seq", if_pc_o, exp_pc);
        check("if_inst_seq", if_inst_o, mem_word(exp_pc));
        exp_pc += 32'd4;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_flush(input logic [31:0] target);
    flush_i    = 1'b1;
    flush_pc_i = target;
    exp_req    = {target[31:2], 2'b00};
    exp_pc     = {target[31:2], 2'b00};
    tick();
    flush_i    = 1'b0;
  endtask

  task automatic drain();
    bus.req_ready = 1'b0;
    repeat (8) tick();
  endtask

  task automatic wait_valid(input int max);
    int k = 0;
    #1;
    while (!if_valid_o && k < max) begin
      tick();
      #1;
      k++;
    end
    check("wait_if_valid", {31'b0, if_valid_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("rst_req_valid", {31'b0, bus.req_valid}, 32'd0);
    check("rst_req_addr",  bus.req_addr, 32'h0);
    check("rst_if_valid",  {31'b0, if_valid_o}, 32'd0);
    check("rst_if_inst",   if_inst_o, 32'h0);
    check("rst_if_pc",     if_pc_o, 32'h0);
    rst_n = 1'b1;

    // Reset release: first request, then 1-cycle-latency pops 0x0, 0x4.
    tick(); #1;
    check("first_req_valid", {31'b0, bus.req_valid}, 32'd1);
    check("first_req_addr",  bus.req_addr, 32'h0);
    tick(); tick(); #1;
    check("first_if_valid", {31'b0, if_valid_o}, 32'd1);
    check("first_if_pc",    if_pc_o, 32'h0);
    check("first_if_inst",  if_inst_o, mem_word(32'h0));
    tick(); #1;
    check("second_if_pc", if_pc_o, 32'h4);
    repeat (20) tick();

    // Hold for 5 cycles: head frozen, credit runs out.
    hold_i = 1'b1;
    tick(); tick(); #1;
    check("hold_if_valid", {31'b0, if_valid_o}, 32'd1);
    check("hold_pc", if_pc_o, exp_pc);
    check("hold_req_off", {31'b0, bus.req_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check("hold_pc", if_pc_o, exp_pc);
      check("hold_req_off", {31'b0, bus.req_valid}, 32'd0);
    end
    tick();
    hold_i = 1'b0;
    repeat (10) tick();

    // Two requests in flight at 0x10/0x14, then flush to 0x203.
    drain();
    lat = 3;
    do_flush(32'h10);
    bus.req_ready = 1'b1;
    tick(); tick(); #1;
    check("inflight_credit", {31'b0, bus.req_valid}, 32'd0);
    do_flush(32'h203);
    wait_valid(20);
    check("stale_if_pc0", if_pc_o, 32'h200);
    check("stale_if_inst0", if_inst_o, mem_word(32'h200));
    tick();
    wait_valid(20);
    check("stale_if_pc1", if_pc_o, 32'h204);
    repeat (4) tick();

    // Flush coincides with the only outstanding response.
    drain();
    lat = 1;
    do_flush(32'h300);
    bus.req_ready = 1'b1;
    tick();
    do_flush(32'h400);
    #1;
    check("rspflush_req_valid", {31'b0, bus.req_valid}, 32'd1);
    check("rspflush_req_addr",  bus.req_addr, 32'h400);
    wait_valid(10);
    check("rspflush_if_pc", if_pc_o, 32'h400);
    repeat (6) tick();

    // Backpressure: request at 0x8 held for 3 cycles.
    drain();
    lat = 1;
    do_flush(32'h8);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_req_valid", {31'b0, bus.req_valid}, 32'd1);
      check("bp_req_addr",  bus.req_addr, 32'h8);
      tick();
    end
    bus.req_ready = 1'b1;
    #1;
    check("bp_req_addr", bus.req_addr, 32'h8);
    tick(); #1;
    check("bp_next_addr", bus.req_addr, 32'hC);
    repeat (6) tick();

    // Wrap-around of the PC, and bypass timing when enabled.
    drain();
    lat = 1;
    do_flush(32'hFFFF_FFFC);
    bus.req_ready = 1'b1;
    #1;
    check("wrap_req_addr0", bus.req_addr, 32'hFFFF_FFFC);
    tick(); #1;
    check("wrap_req_addr1", bus.req_addr, 32'h0);
`ifdef FETCH_BYPASS_EN
    check("byp_if_valid", {31'b0, if_valid_o}, 32'd1);
    check("byp_if_pc", if_pc_o, 32'hFFFF_FFFC);
`else
    check("wrap_if_valid_lat", {31'b0, if_valid_o}, 32'd0);
    tick(); #1;
    check("wrap_if_pc", if_pc_o, 32'hFFFF_FFFC);
`endif
    repeat (8) tick();

    // Reset in the middle of traffic.
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", {31'b0, bus.req_valid}, 32'd0);
    check("midrst_req_addr",  bus.req_addr, 32'h0);
    check("midrst_if_valid",  {31'b0, if_valid_o}, 32'd0);
    check("midrst_if_pc",     if_pc_o, 32'h0);
    exp_req = '0;
    exp_pc  = '0;
    tick(); tick();
    rst_n = 1'b1;
    wait_valid(10);
    check("midrst_first_pc", if_pc_o, 32'h0);
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
